// File: rtl/config_chain_pkg.sv
// config_chain_pkg: shared FSM state type and CRC-8 serial step for the chain loader.
package config_chain_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FIN} state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // MSB-first Galois step: feedback is the outgoing MSB xor the new bit
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 accumulator with synchronous clear and update enable.
module crc8_serial
   import config_chain_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);

   logic [7:0] crc_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) crc_q <= '0;
      else if (clr) crc_q <= '0;
      else if (en) crc_q <= crc8_step(crc_q, din);

   assign crc = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: streams configuration words LSB-first into a scan chain
// and accumulates a CRC-8 of the previous chain contents read back from the tail.
module config_chain_loader
   import config_chain_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CHAIN_LEN = 64
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              sc_head,
   output logic              sc_en,
   input  logic              sc_tail,
   output logic              busy,
   output logic              done,
   output logic [7:0]        rb_crc
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W  = $clog2(DATA_W + 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WB_W-1:0]   wbit_q, wbit_d;
   logic [CNT_W-1:0]  left;

   // bits still owed to the chain; a short final word only shifts this many
   assign left = CNT_W'(CHAIN_LEN) - bit_cnt_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         wbit_q    <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         wbit_q    <= wbit_d;
      end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      wbit_d    = wbit_q;
      cfg_ready = state_q == FETCH;
      sc_en     = state_q == SHIFT && !abort;
      sc_head   = state_q == SHIFT && shreg_q[0];
      busy      = state_q != IDLE;
      done      = state_q == FIN && !abort;
      if (abort && state_q != IDLE)
         state_d = IDLE;
      else
         unique case (state_q)
            IDLE:
               if (start) begin
                  state_d   = FETCH;
                  bit_cnt_d = '0;
               end
            FETCH:
               if (cfg_valid) begin
                  state_d = SHIFT;
                  shreg_d = cfg_data;
                  wbit_d  = (32'(left) < DATA_W) ? WB_W'(left) : WB_W'(DATA_W);
               end
            SHIFT: begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               wbit_d    = wbit_q - 1'b1;
               if (wbit_q == WB_W'(1))
                  state_d = (32'(bit_cnt_q) == CHAIN_LEN - 1) ? FIN : FETCH;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
         endcase
   end

   crc8_serial u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start && state_q == IDLE),
      .en      (sc_en),
      .din     (sc_tail),
      .crc     (rb_crc)
   );

endmodule
